// File: rtl/logic_unit_pipe_if.sv
// Handshake bus of the logic unit: operand side (a/b/op/valid_i/ready_o)
// and result side (c/flags/valid_o/ready_i). The slave modport is the
// block itself; the master modport is whoever feeds and drains it.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [2:0]       op_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] c_o;
    logic             zero_o;
    logic             parity_o;
    logic             valid_o;
    logic             ready_i;

    modport master (
        output a_i, b_i, op_i, valid_i, ready_i,
        input  ready_o, c_o, zero_o, parity_o, valid_o
    );

    modport slave (
        input  a_i, b_i, op_i, valid_i, ready_i,
        output ready_o, c_o, zero_o, parity_o, valid_o
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit bitwise logic unit with a one-entry skid buffer.
// The main register drives the outputs; the skid register catches the one
// extra result accepted while downstream stalls, so ready_o can be a flop.

// One result bit: the eight operations reduce to a per-bit truth table.
module logic_unit_lane (
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       c
);
    // Select the operation for this bit position
    always_comb begin
        case (op)
            3'b000:  c = a & b;
            3'b001:  c = a | b;
            3'b010:  c = a ^ b;
            3'b011:  c = ~(a & b);
            3'b100:  c = ~(a | b);
            3'b101:  c = ~(a ^ b);
            3'b110:  c = a & ~b;
            default: c = a;
        endcase
    end
endmodule

module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    logic_unit_pipe_if.slave   bus,
    input  logic               clear_i,
    output logic [CNT_W-1:0]   count_o
);
    typedef struct packed {
        logic [WIDTH-1:0] c;
        logic             zero;
        logic             parity;
    } result_t;

    // EMPTY: nothing held; BUSY: main valid; FULL: main and skid valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    result_t          main_q;
    result_t          skid_q;
    result_t          new_res;
    logic             valid_q;
    logic             ready_q;
    logic [WIDTH-1:0] lane_c;
    logic             accept;
    logic             deliver;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            logic_unit_lane u_lane (
                .op (bus.op_i),
                .a  (bus.a_i[gi]),
                .b  (bus.b_i[gi]),
                .c  (lane_c[gi])
            );
        end
    endgenerate

    // Flags are formed alongside the result so they ride in the same register
    always_comb begin
        new_res.c      = lane_c;
        new_res.zero   = (lane_c == '0);
        new_res.parity = ^lane_c;
    end

    assign accept  = bus.valid_i & ready_q;
    assign deliver = valid_q & bus.ready_i;

    // Occupancy FSM; valid_o/ready_o are registered from the next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= new_res;
                        state   <= BUSY;
                        valid_q <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && deliver) begin
                        main_q <= new_res;
                    end else if (accept) begin
                        // Downstream stalled: park the new result, hold main
                        skid_q  <= new_res;
                        state   <= FULL;
                        ready_q <= 1'b0;
                    end else if (deliver) begin
                        state   <= EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        main_q  <= skid_q;
                        state   <= BUSY;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Saturating delivered-result counter; clear wins over a same-cycle deliver
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_o <= '0;
        end else if (deliver && (count_o != CNT_MAX)) begin
            count_o <= count_o + 1'b1;
        end
    end

    assign bus.c_o      = main_q.c;
    assign bus.zero_o   = main_q.zero;
    assign bus.parity_o = main_q.parity;
    assign bus.valid_o  = valid_q;
    assign bus.ready_o  = ready_q;
endmodule
